// File: rtl/tiny_proc_pkg.sv
// rtl/tiny_proc_pkg.sv - shared state encoding and opcode constants for the tiny processor
package tiny_proc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT,
        PAUSE
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register with load, wrapping increment and hold
module pc_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_value,
    input  logic                incr,
    output logic [PC_WIDTH-1:0] pc
);

    // Natural modulo-2**PC_WIDTH overflow gives the required wrap to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning PC and IR
// Optional single-step mode (PAUSE state, Step port) is enabled by defining SINGLE_STEP_EN.
module instr_sequencer
    import tiny_proc_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   Enable,
    input  logic [INSTR_WIDTH-1:0] Instr,
    input  logic                   Branch_Taken,
    input  logic [PC_WIDTH-1:0]    Branch_Target,
    input  logic                   Halt_Req,
    input  logic                   Resume,
`ifdef SINGLE_STEP_EN
    input  logic                   Step,
`endif
    output logic [PC_WIDTH-1:0]    PC,
    output logic [INSTR_WIDTH-1:0] IR,
    output logic                   Mem_Rd,
    output logic                   Decode_En,
    output logic                   Exec_En,
    output logic                   Wb_En,
    output logic                   Busy,
    output logic                   Halted
);

    state_t state;
    state_t next_state;

    logic nx_mem_rd, nx_decode_en, nx_exec_en, nx_wb_en, nx_busy, nx_halted;
    logic                br_taken_q;
    logic [PC_WIDTH-1:0] br_target_q;

    // Strobes are registered from the next-state decode so they line up with state.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Mem_Rd    <= 1'b0;
            Decode_En <= 1'b0;
            Exec_En   <= 1'b0;
            Wb_En     <= 1'b0;
            Busy      <= 1'b0;
            Halted    <= 1'b0;
        end else begin
            state     <= next_state;
            Mem_Rd    <= nx_mem_rd;
            Decode_En <= nx_decode_en;
            Exec_En   <= nx_exec_en;
            Wb_En     <= nx_wb_en;
            Busy      <= nx_busy;
            Halted    <= nx_halted;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (Enable) next_state = FETCH;
            FETCH:     next_state = DECODE;
            DECODE:    next_state = (Instr[OPC_MSB:OPC_LSB] == OP_HALT) ? HALT : EXECUTE;
            EXECUTE:   next_state = WRITEBACK;
            WRITEBACK: begin
                if (Halt_Req)
                    next_state = HALT;
                else if (Enable)
`ifdef SINGLE_STEP_EN
                    next_state = PAUSE;
`else
                    next_state = FETCH;
`endif
                else
                    next_state = IDLE;
            end
            HALT:      if (Resume) next_state = FETCH;
`ifdef SINGLE_STEP_EN
            PAUSE: begin
                if (Halt_Req)
                    next_state = HALT;
                else if (Step)
                    next_state = FETCH;
                else if (!Enable)
                    next_state = IDLE;
            end
`endif
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        nx_mem_rd    = (next_state == FETCH);
        nx_decode_en = (next_state == DECODE);
        nx_exec_en   = (next_state == EXECUTE);
        nx_wb_en     = (next_state == WRITEBACK);
        nx_busy      = (next_state == FETCH) || (next_state == DECODE) ||
                       (next_state == EXECUTE) || (next_state == WRITEBACK);
        nx_halted    = (next_state == HALT);
    end

    // Memory data is valid during DECODE, so IR loads on the edge leaving DECODE.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            IR          <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            if (state == DECODE)
                IR <= Instr;
            if (state == EXECUTE) begin
                br_taken_q  <= Branch_Taken;
                br_target_q <= Branch_Target;
            end
        end
    end

    pc_unit #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .load       ((state == WRITEBACK) && br_taken_q),
        .load_value (br_target_q),
        .incr       ((state == WRITEBACK) && !br_taken_q),
        .pc         (PC)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench: instruction-level model predicts every cycle
module tb_instr_sequencer;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DEC   = 2;
    localparam int P_EXEC  = 3;
    localparam int P_WB    = 4;
    localparam int P_HALT  = 5;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [5:0]  st;
        int          ph;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Enable;
    logic [15:0] Instr;
    logic        Branch_Taken;
    logic [7:0]  Branch_Target;
    logic        Halt_Req;
    logic        Resume;
`ifdef SINGLE_STEP_EN
    logic        Step = 1'b0;
`endif
    logic [7:0]  PC;
    logic [15:0] IR;
    logic        Mem_Rd, Decode_En, Exec_En, Wb_En, Busy, Halted;

    exp_t        exp_q[$];
    logic [15:0] mem [256];
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    int          m_mode;
    int          n_tests = 0;
    int          n_fail  = 0;

    instr_sequencer dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Enable        (Enable),
        .Instr         (Instr),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Halt_Req      (Halt_Req),
        .Resume        (Resume),
`ifdef SINGLE_STEP_EN
        .Step          (Step),
`endif
        .PC            (PC),
        .IR            (IR),
        .Mem_Rd        (Mem_Rd),
        .Decode_En     (Decode_En),
        .Exec_En       (Exec_En),
        .Wb_En         (Wb_En),
        .Busy          (Busy),
        .Halted        (Halted)
    );

    always #5 Clock = ~Clock;

    // {Mem_Rd, Decode_En, Exec_En, Wb_En, Busy, Halted} for each phase
    function automatic logic [5:0] strobes(input int ph);
        case (ph)
            P_FETCH: return 6'b100010;
            P_DEC:   return 6'b010010;
            P_EXEC:  return 6'b001010;
            P_WB:    return 6'b000110;
            P_HALT:  return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic r1();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    function automatic logic [15:0] r16();
        return 16'($urandom);
    endfunction

    always @(posedge Clock) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({PC, IR, Mem_Rd, Decode_En, Exec_En, Wb_En, Busy, Halted} !== {e.pc, e.ir, e.st}) begin
                n_fail++;
                $display("FAIL cycle_check phase=%0d: got pc=%h ir=%h strobes=%b, expected pc=%h ir=%h strobes=%b",
                         e.ph, PC, IR, {Mem_Rd, Decode_En, Exec_En, Wb_En, Busy, Halted}, e.pc, e.ir, e.st);
            end
        end
    end

    task automatic check_now(input string name, input logic [29:0] act, input logic [29:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Apply inputs for the coming edge and queue the expected post-edge outputs.
    task automatic tick(input logic en, input logic [15:0] ins, input logic bt, input logic [7:0] tg,
                        input logic hr, input logic rs, input int ph);
        exp_t e;
        Enable        = en;
        Instr         = ins;
        Branch_Taken  = bt;
        Branch_Target = tg;
        Halt_Req      = hr;
        Resume        = rs;
        e.pc = m_pc;
        e.ir = m_ir;
        e.st = strobes(ph);
        e.ph = ph;
        exp_q.push_back(e);
        @(negedge Clock);
    endtask

    task automatic from_idle();
        tick(1'b1, r16(), r1(), r8(), r1(), r1(), P_FETCH);
        m_mode = M_RUN;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, r16(), r1(), r8(), r1(), r1(), P_IDLE);
    endtask

    task automatic halt_ticks(input int n);
        for (int i = 0; i < n; i++)
            tick(r1(), r16(), r1(), r8(), r1(), 1'b0, P_HALT);
    endtask

    task automatic resume();
        tick(r1(), r16(), r1(), r8(), r1(), 1'b1, P_FETCH);
        m_mode = M_RUN;
    endtask

    // Called with the DUT in FETCH; runs one instruction from mem[m_pc].
    task automatic do_instr(input logic bt, input logic [7:0] tg, input logic hr, input logic en_next);
        logic [15:0] ins;
        ins = mem[m_pc];
        tick(r1(), r16(), r1(), r8(), r1(), r1(), P_DEC);
        m_ir = ins;
        if (ins[15:12] == 4'hF) begin
            tick(r1(), ins, r1(), r8(), r1(), r1(), P_HALT);
            m_mode = M_HALT;
            return;
        end
        tick(r1(), ins, r1(), r8(), r1(), r1(), P_EXEC);
        tick(r1(), r16(), bt, tg, r1(), r1(), P_WB);
        m_pc = bt ? tg : m_pc + 8'd1;
        if (hr) begin
            tick(en_next, r16(), r1(), r8(), 1'b1, r1(), P_HALT);
            m_mode = M_HALT;
        end else if (en_next) begin
            tick(1'b1, r16(), r1(), r8(), 1'b0, r1(), P_FETCH);
            m_mode = M_RUN;
        end else begin
            tick(1'b0, r16(), r1(), r8(), 1'b0, r1(), P_IDLE);
            m_mode = M_IDLE;
        end
    endtask

    task automatic do_reset();
        exp_t e;
        Reset_n  = 1'b0;
        Enable   = 1'b1;
        Resume   = 1'b1;
        Halt_Req = 1'b1;
        m_pc     = 8'h00;
        m_ir     = 16'h0000;
        e.pc = m_pc;
        e.ir = m_ir;
        e.st = strobes(P_IDLE);
        e.ph = P_IDLE;
        exp_q.push_back(e);
        #1;
        check_now("async_reset", {PC, IR, Mem_Rd, Decode_En, Exec_En, Wb_En, Busy, Halted}, 30'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        m_mode  = M_IDLE;
    endtask

    initial begin
        Reset_n = 1'b0;
        Enable = 1'b0; Instr = '0; Branch_Taken = 1'b0; Branch_Target = '0;
        Halt_Req = 1'b0; Resume = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        @(negedge Clock);
        do_reset();

        // NOP stream from reset: PC 0,1,2 then drop Enable
        from_idle();
        do_instr(1'b0, 8'h00, 1'b0, 1'b1);
        do_instr(1'b0, 8'h00, 1'b0, 1'b1);
        do_instr(1'b0, 8'h00, 1'b0, 1'b0);
        idle_ticks(2);

        // PC wrap 8'hFF -> 8'h00 without a stall
        from_idle();
        do_instr(1'b1, 8'hFF, 1'b0, 1'b1);
        do_instr(1'b0, 8'h00, 1'b0, 1'b1);

        // Taken branch at PC=5 to 8'h20
        do_instr(1'b1, 8'h05, 1'b0, 1'b1);
        do_instr(1'b1, 8'h20, 1'b0, 1'b1);

        // HALT opcode at PC=3, resume re-executes it
        mem[3] = 16'hF000;
        do_instr(1'b1, 8'h03, 1'b0, 1'b1);
        do_instr(1'b0, 8'h00, 1'b0, 1'b1);
        halt_ticks(3);
        resume();
        do_instr(1'b0, 8'h00, 1'b0, 1'b1);
        mem[3] = 16'h0000;
        resume();
        do_instr(1'b0, 8'h00, 1'b0, 1'b1);

        // Halt_Req with a taken branch, then reset mid-FETCH
        do_instr(1'b1, 8'h40, 1'b1, 1'b1);
        halt_ticks(1);
        resume();
        do_reset();

        // Randomized instruction stream
        for (int i = 0; i < 256; i++) begin
            logic [15:0] v;
            v = r16();
            if ($urandom_range(0, 7) == 0) v[15:12] = 4'hF;
            else if (v[15:12] == 4'hF) v[15:12] = 4'h0;
            mem[i] = v;
        end
        for (int i = 0; i < 150; i++) begin
            if (m_mode == M_IDLE) begin
                idle_ticks($urandom_range(0, 2));
                from_idle();
            end else if (m_mode == M_HALT) begin
                halt_ticks($urandom_range(0, 2));
                if (mem[m_pc][15:12] == 4'hF) mem[m_pc] = 16'($urandom_range(0, 16'hEFFF));
                resume();
            end
            do_instr($urandom_range(0, 3) == 0, r8(), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end

        repeat (3) @(negedge Clock);
        check_now("queue_drained", 30'(exp_q.size()), 30'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
